// File: rtl/smf_pkg.sv
// Shared types and constants for the switching median filter.
// Window tap numbering, pixel width default and sequencer states.
package smf_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int WIN_TAPS  = 9;
    localparam int WIN_W_DEF = WIN_TAPS * PIX_W_DEF;

    // Tap positions inside a packed window, raster order.
    localparam int X_TL   = 0;
    localparam int CENTRE = 4;
    localparam int X_BR   = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/smf_line_buffer.sv
// Two-row line store for the window sequencer.
// Ports: clk, en (accept), addr (column), din (new pixel),
//        lb0_q (row above), lb1_q (two rows above); reads are old values.
module smf_line_buffer #(
    parameter int IMG_W = 8,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] lb0_q,
    output logic [PIX_W-1:0] lb1_q
);

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    assign lb0_q = lb0[addr];
    assign lb1_q = lb1[addr];

    // Contents need no reset: a frame always overwrites a row
    // before it is read back as part of a window.
    always_ff @(posedge clk) begin
        if (en) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= din;
        end
    end

endmodule

// File: rtl/smf_window_sequencer.sv
// Raster-to-3x3-window sequencer for the switching median filter.
// Ports: clk, rst_n, start; in_valid/in_ready/in_pixel (raster input);
//        win_valid/win_ready/win_data/win_last (window output);
//        busy, frame_done (status).
module smf_window_sequencer
    import smf_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W-1:0]          in_pixel,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [WIN_TAPS*PIX_W-1:0] win_data,
    output logic                      win_last,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    state_t state, state_n;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          emit;
    logic          at_last;
    logic          done_n;

    logic [PIX_W-1:0] lb0_q, lb1_q;
    // lcol/mcol are the two most recent columns; the incoming
    // column completes the window, so no third register is needed.
    logic [PIX_W-1:0] lcol [3];
    logic [PIX_W-1:0] mcol [3];
    logic [PIX_W-1:0] ncol [3];
    logic [WIN_TAPS*PIX_W-1:0] win_next;

    assign in_ready = (state == S_FILL || state == S_RUN)
                    && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign at_last  = (row == ROW_MAX) && (col == COL_MAX);
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign busy     = (state != S_IDLE);

    smf_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_lb (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .din   (in_pixel),
        .lb0_q (lb0_q),
        .lb1_q (lb1_q)
    );

    assign ncol[0] = lb1_q;
    assign ncol[1] = lb0_q;
    assign ncol[2] = in_pixel;

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[(3*r+0)*PIX_W +: PIX_W] = lcol[r];
            win_next[(3*r+1)*PIX_W +: PIX_W] = mcol[r];
            win_next[(3*r+2)*PIX_W +: PIX_W] = ncol[r];
        end
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_n = S_FILL;
            S_FILL: begin
                if (accept && row == RW'(2) && col == CW'(1))
                    state_n = S_RUN;
            end
            S_RUN: if (accept && at_last) state_n = S_DONE;
            S_DONE: begin
                if (!win_valid || win_ready) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            frame_done <= done_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == S_IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                lcol[r] <= mcol[r];
                mcol[r] <= ncol[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_next;
            win_last  <= at_last;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_smf_window_sequencer.sv
// Scoreboard bench for smf_window_sequencer: 4x4 and 8x5 instances.
// Drivers queue expected windows; negedge monitors pop and compare.
module tb_smf_window_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // 4x4 instance
    logic        start4 = 0, in_valid4 = 0, win_ready4 = 1;
    logic [7:0]  in_pixel4 = '0;
    logic        in_ready4, win_valid4, win_last4, busy4, frame_done4;
    logic [71:0] win_data4;

    // 8x5 instance
    logic        start8 = 0, in_valid8 = 0, win_ready8 = 1;
    logic [7:0]  in_pixel8 = '0;
    logic        in_ready8, win_valid8, win_last8, busy8, frame_done8;
    logic [71:0] win_data8;

    smf_window_sequencer #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_pixel(in_pixel4),
        .win_valid(win_valid4), .win_ready(win_ready4),
        .win_data(win_data4), .win_last(win_last4),
        .busy(busy4), .frame_done(frame_done4)
    );

    smf_window_sequencer #(.IMG_W(8), .IMG_H(5), .PIX_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_pixel(in_pixel8),
        .win_valid(win_valid8), .win_ready(win_ready8),
        .win_data(win_data8), .win_last(win_last8),
        .busy(busy8), .frame_done(frame_done8)
    );

    // Hand-computed windows of the 4x4 frame, pixel = 16*r + c.
    localparam int EXP4 [4][9] = '{
        '{ 0,  1,  2, 16, 17, 18, 32, 33, 34},
        '{ 1,  2,  3, 17, 18, 19, 33, 34, 35},
        '{16, 17, 18, 32, 33, 34, 48, 49, 50},
        '{17, 18, 19, 33, 34, 35, 49, 50, 51}
    };

    logic [72:0] q4 [$];
    logic [72:0] q8 [$];
    int got4 = 0, got8 = 0;
    int stall_at = 0;
    bit stall_arm = 0;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor for the 4x4 instance.
    initial begin
        logic [71:0] prev_data;
        logic [72:0] e;
        bit prev_stall;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (win_valid4 && !win_ready4) begin
                    chk("stall_in_ready4", 80'(in_ready4), 80'(0));
                    if (prev_stall)
                        chk("stall_hold4", 80'(win_data4), 80'(prev_data));
                    prev_stall = 1;
                    prev_data  = win_data4;
                end else begin
                    prev_stall = 0;
                end
                if (win_valid4 && win_ready4) begin
                    got4++;
                    if (q4.size() == 0) begin
                        chk("unexpected_win4", 80'(1), 80'(0));
                    end else begin
                        e = q4.pop_front();
                        chk("win4", 80'({win_last4, win_data4}), 80'(e));
                    end
                end
            end
        end
    end

    // Monitor for the 8x5 instance, also checks back-to-back windows.
    initial begin
        logic [72:0] e;
        int last_cyc;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n && win_valid8 && win_ready8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_win8", 80'(1), 80'(0));
                end else begin
                    e = q8.pop_front();
                    chk("win8", 80'({win_last8, win_data8}), 80'(e));
                end
                if (got8 % 6 != 0)
                    chk("win8_back_to_back", 80'(cyc), 80'(last_cyc + 1));
                last_cyc = cyc;
                got8++;
            end
        end
    end

    // Drops win_ready4 for 3 cycles after the armed window count.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm && got4 >= stall_at) begin
                stall_arm  = 0;
                win_ready4 = 0;
                repeat (3) @(posedge clk);
                #1;
                win_ready4 = 1;
            end
        end
    end

    function automatic logic [72:0] exp4_win(input int k);
        logic [72:0] w;
        w = '0;
        for (int t = 0; t < 9; t++) w[t*8 +: 8] = 8'(EXP4[k][t]);
        w[72] = (k == 3);
        return w;
    endfunction

    function automatic logic [72:0] exp8_win(input int k);
        logic [72:0] w;
        int r, c;
        r = 1 + k / 6;
        c = 1 + k % 6;
        w = '0;
        for (int t = 0; t < 9; t++)
            w[t*8 +: 8] = 8'(16 * (r - 1 + t / 3) + (c - 1 + t % 3));
        w[72] = (k == 17);
        return w;
    endfunction

    task automatic start_frame4();
        @(posedge clk); #1;
        start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        @(negedge clk);
        chk("start_busy4", 80'(busy4), 80'(1));
        chk("start_in_ready4", 80'(in_ready4), 80'(1));
        @(posedge clk); #1;
    endtask

    task automatic feed4(input int n, input bit gap, input bit smid);
        bit iv, acc;
        int i, guard;
        iv = 1; i = 0; guard = 0;
        while (i < n && guard < 200) begin
            in_valid4 = iv;
            in_pixel4 = 8'(16 * (i / 4) + i % 4);
            start4    = smid && (i == 5);
            @(negedge clk);
            acc = in_valid4 && in_ready4;
            @(posedge clk); #1;
            if (acc) i++;
            if (gap) iv = !iv;
            guard++;
        end
        in_valid4 = 0;
        start4    = 0;
        if (i < n) chk("feed4_timeout", 80'(i), 80'(n));
    endtask

    task automatic finish_frame4(input int base);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!frame_done4 && guard < 60);
        chk("frame_done4", 80'(frame_done4), 80'(1));
        chk("idle_busy4", 80'(busy4), 80'(0));
        chk("idle_in_ready4", 80'(in_ready4), 80'(0));
        @(negedge clk);
        chk("frame_done4_pulse", 80'(frame_done4), 80'(0));
        chk("win_count4", 80'(got4 - base), 80'(4));
        chk("queue_empty4", 80'(q4.size()), 80'(0));
    endtask

    task automatic frame4(input bit gap, input bit smid, input bit stall);
        int base;
        base = got4;
        for (int k = 0; k < 4; k++) q4.push_back(exp4_win(k));
        if (stall) begin
            stall_at  = got4 + 1;
            stall_arm = 1;
        end
        start_frame4();
        feed4(16, gap, smid);
        finish_frame4(base);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 80'(in_ready4), 80'(0));
        chk("rst_win_valid", 80'(win_valid4), 80'(0));
        chk("rst_win_last", 80'(win_last4), 80'(0));
        chk("rst_busy", 80'(busy4), 80'(0));
        chk("rst_frame_done", 80'(frame_done4), 80'(0));
        chk("rst_win_data", 80'(win_data4), 80'(0));
    endtask

    initial begin
        bit acc;
        int i, guard;

        repeat (2) @(posedge clk);
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;

        frame4(0, 0, 0);
        frame4(0, 0, 1);
        frame4(1, 0, 0);
        frame4(0, 1, 0);

        // Partial frame of 9 accepts, then asynchronous reset.
        start_frame4();
        feed4(9, 0, 0);
        #2;
        rst_n = 0;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;
        frame4(0, 0, 0);

        // 8x5 streaming frame.
        for (int k = 0; k < 18; k++) q8.push_back(exp8_win(k));
        @(posedge clk); #1;
        start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
        i = 0; guard = 0;
        while (i < 40 && guard < 200) begin
            in_valid8 = 1;
            in_pixel8 = 8'(16 * (i / 8) + i % 8);
            @(negedge clk);
            acc = in_valid8 && in_ready8;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid8 = 0;
        chk("feed8_no_stall", 80'(guard), 80'(40));
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!frame_done8 && guard < 60);
        chk("frame_done8", 80'(frame_done8), 80'(1));
        chk("idle_busy8", 80'(busy8), 80'(0));
        chk("win_count8", 80'(got8), 80'(18));
        chk("queue_empty8", 80'(q8.size()), 80'(0));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/smf_window_sequencer.md
# smf_window_sequencer

Raster-to-window controller for the switching median filter. It accepts a frame one pixel at a time, keeps the two previous image rows in line buffers, and emits one 3x3 window per interior pixel to the noise detector and median stages through a valid/ready handshake. It controls frame start, fill, streaming and end-of-frame, so the detector only ever sees complete, correctly ordered windows.

## Interface
- IMG_W, default 8: image width in pixels; must be ≥ 3.
- IMG_H, default 8: image height in pixels; must be ≥ 3.
- PIX_W, default 8: pixel width in bits.
- clk  in  1  the single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  in_pixel holds valid data.
- in_ready  out  1  the block accepts in_pixel this cycle.
- in_pixel  in  PIX_W  raster-order pixel.
- win_valid  out  1  win_data holds a valid window.
- win_ready  in  1  the downstream stage accepts the window.
- win_data  out  9*PIX_W  the window. X0 (top-left) is at [PIX_W-1:0]; X1..X8 follow in raster order; X4 is the centre.
- win_last  out  1  marks the last window of the frame; qualified by win_valid.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the frame is complete.

## Operation
- States:
  - IDLE: in_ready = 0. On start, go to FILL.
  - FILL: accepts pixels; no windows are produced.
  - RUN: accepts pixels and produces windows.
  - DONE: no input accepted; waits for the final window to drain.
- Transitions:
  - FILL → RUN on the accepted pixel at (row 2, col 1).
  - RUN → DONE on the accepted pixel at (IMG_H-1, IMG_W-1).
  - DONE → IDLE when win_valid = 0 or the last window handshakes.
  - frame_done pulses in the cycle after that transition.
- Accept condition: in_valid & in_ready.
  - in_ready = (FILL or RUN) & (!win_valid | win_ready).
- Counters:
  - col wraps from IMG_W-1 to 0 and then increments row.
  - row and col clear on start.
- On each accepted pixel p at column c:
  - Build a new column {lb1[c], lb0[c], p} (top to bottom).
  - Shift the 3x3 column registers left and insert the new column.
  - Update the line buffers: lb1[c] ← lb0[c], lb0[c] ← p.
- Window emission:
  - Emitted when the accept has row ≥ 2 and col ≥ 2.
  - The window is centred on (row-1, col-1).
  - Only interior pixels get windows: (IMG_W-2)*(IMG_H-2) windows per frame; edges are not padded.
  - Stale column-register contents at c = 0 and c = 1 are never emitted.
- Output register:
  - Single-entry.
  - win_valid set on emission.
  - win_valid cleared on a handshake with no new emission.
  - win_data and win_last hold stable while win_valid & !win_ready.
- start while busy is ignored.
- Line-buffer contents are don't-care after reset. Only the counters and the FSM are reset.

## Timing
- Reset values: state = IDLE; in_ready, win_valid, win_last, busy and frame_done all 0; win_data = 0.
- start in cycle t gives busy = 1 and in_ready = 1 in cycle t+1.
- Latency: the accept that completes a window gives win_valid in the next cycle.
- Throughput: one pixel and one window per cycle while win_ready stays high.
- Backpressure:
  - win_valid & !win_ready forces in_ready = 0 in the same cycle (combinational).
  - No pixel is ever dropped or duplicated.
- Simultaneous handshake and new emission: win_data is replaced and win_valid stays 1.
- Asynchronous reset mid-frame:
  - All outputs return to reset values immediately.
  - The partial frame is discarded.
  - A new start is required.

## Structure
- Package smf_pkg:
  - PIX_W default.
  - WIN_W = 9*PIX_W.
  - State enum {IDLE, FILL, RUN, DONE}.
  - Window index constants (CENTRE = 4).
- Sub-module smf_line_buffer:
  - Two IMG_W-deep PIX_W-wide arrays with a shared column address.
  - Outputs the read-old values lb1[c] and lb0[c].
  - Performs the shift-write on an accept enable.
- Top level: FSM, counters, 3x3 column registers, output register.

## Test plan
- Basic frame: IMG_W = IMG_H = 4, pixel value = 16*r + c, win_ready = 1 throughout → exactly 4 windows.
  - First window: 0,1,2,16,17,18,32,33,34.
  - Last window: 17,18,19,33,34,35,49,50,51, with win_last = 1.
  - Then a frame_done pulse, then IDLE.
- Backpressure: same frame with win_ready low for 3 cycles after the first window → win_data stable, in_ready = 0, identical window sequence.
- Input gaps: same frame with in_valid toggling 1,0,1,0 → same 4 windows, no extra win_valid pulses.
- Ignored start: a start pulse mid-frame → no effect on counters or output.
- Reset mid-frame: rst_n low after 9 accepts → outputs return to reset values; a fresh start followed by a full 4x4 frame yields the correct 4 windows.
- Throughput and count: IMG_W = 8, IMG_H = 5, continuous valid/ready → 18 windows on consecutive cycles per row, and win_last only on the 18th window.
